// File: rtl/pam_mult_pkg.sv
// Shared mode encodings and width helper for the approximate multiplier pipeline.
package pam_mult_pkg;

    localparam logic MODE_EXACT  = 1'b0;
    localparam logic MODE_APPROX = 1'b1;

    function automatic int prod_w(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/pam_approx_pp_compress.sv
// Compensation term for the approximated low multiplier rows: pairwise OR of partial products per column.
// Purely combinational; no latency, no flow control.
module pam_approx_pp_compress
    import pam_mult_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int L        = 4,
    parameter int KEEP_COL = WIDTH
) (
    input  logic [WIDTH-1:0]          x,
    input  logic [WIDTH-1:0]          y,
    output logic [prod_w(WIDTH)-1:0]  comp
);

    localparam int PW = prod_w(WIDTH);
    localparam int NC = PW - 1;
    localparam int NK = (L + 1) / 2;
    localparam int NT = (NC - KEEP_COL) * NK;

    // High x bits and some low y bits never reach a kept column.
    logic unused_bits;
    assign unused_bits = ^{x, y};

    // Running sum through every (column, row pair) term.
    logic [PW-1:0] part [NT+1];
    assign part[0] = '0;

    for (genvar gc = KEEP_COL; gc < NC; gc++) begin : g_col
        for (genvar gk = 0; gk < NK; gk++) begin : g_pair
            localparam int IDX = (gc - KEEP_COL) * NK + gk;
            localparam int R0  = 2 * gk;
            localparam int R1  = 2 * gk + 1;
            localparam int I0  = gc - R0;
            localparam int I1  = gc - R1;
            logic b0;
            logic b1;
            if (I0 >= 0 && I0 < WIDTH) begin : g_b0
                assign b0 = x[R0] & y[I0];
            end else begin : g_b0_none
                assign b0 = 1'b0;
            end
            if (R1 < L && I1 >= 0 && I1 < WIDTH) begin : g_b1
                assign b1 = x[R1] & y[I1];
            end else begin : g_b1_none
                assign b1 = 1'b0;
            end
            assign part[IDX+1] = part[IDX] + (PW'(b0 | b1) << gc);
        end
    end

    assign comp = part[NT];

endmodule

// File: rtl/pam_approx_mult_pipe.sv
// Pipelined unsigned multiplier with per-op exact/approximate mode; latency STAGES cycles.
// Whole pipe advances only when the output slot is empty or being taken; in_ready = that advance.
module pam_approx_mult_pipe
    import pam_mult_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int L        = 4,
    parameter int KEEP_COL = WIDTH,
    parameter int STAGES   = 2,
    parameter int TAG_W    = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_x,
    input  logic [WIDTH-1:0]         in_y,
    input  logic                     in_mode,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [prod_w(WIDTH)-1:0] out_z,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     out_mode,
    output logic [31:0]              approx_cnt
);

    localparam int PW = prod_w(WIDTH);

    logic [PW-1:0] exact_z;
    logic [PW-1:0] high_z;
    logic [PW-1:0] comp_z;
    logic [PW-1:0] prod_z;
    logic          adv;

    logic             vld_q  [STAGES];
    logic             vld_d  [STAGES];
    logic [PW-1:0]    z_q    [STAGES];
    logic [PW-1:0]    z_d    [STAGES];
    logic [TAG_W-1:0] tag_q  [STAGES];
    logic [TAG_W-1:0] tag_d  [STAGES];
    logic             mode_q [STAGES];
    logic             mode_d [STAGES];
    logic [31:0]      cnt_q;
    logic [31:0]      cnt_d;

    pam_approx_pp_compress #(
        .WIDTH    (WIDTH),
        .L        (L),
        .KEEP_COL (KEEP_COL)
    ) u_compress (
        .x    (in_x),
        .y    (in_y),
        .comp (comp_z)
    );

    assign exact_z = PW'(in_x) * PW'(in_y);
    assign high_z  = (PW'(in_y) * PW'(in_x[WIDTH-1:L])) << L;

    always_comb begin
        prod_z = exact_z;
        if (in_mode == MODE_APPROX) begin
            prod_z = high_z + comp_z;
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;

    // Stall freezes every stage, bubbles included, so cycle timing stays fixed.
    always_comb begin
        vld_d  = vld_q;
        z_d    = z_q;
        tag_d  = tag_q;
        mode_d = mode_q;
        if (adv) begin
            vld_d[0]  = in_valid;
            z_d[0]    = prod_z;
            tag_d[0]  = in_tag;
            mode_d[0] = in_mode;
            for (int s = 1; s < STAGES; s++) begin
                vld_d[s]  = vld_q[s-1];
                z_d[s]    = z_q[s-1];
                tag_d[s]  = tag_q[s-1];
                mode_d[s] = mode_q[s-1];
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (out_valid && out_ready && (out_mode == MODE_APPROX) && (cnt_q != '1)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '{default: 1'b0};
            z_q    <= '{default: '0};
            tag_q  <= '{default: '0};
            mode_q <= '{default: 1'b0};
            cnt_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            z_q    <= z_d;
            tag_q  <= tag_d;
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
        end
    end

    assign out_z      = z_q[STAGES-1];
    assign out_tag    = tag_q[STAGES-1];
    assign out_mode   = mode_q[STAGES-1];
    assign approx_cnt = cnt_q;

endmodule

// File: tb/tb_pam_approx_mult_pipe.sv
// Scoreboard bench: default 8x8/L=4 instance plus a 12x12/L=5/KEEP_COL=10 instance.
module tb_pam_approx_mult_pipe;

    typedef struct {
        logic [63:0] z;
        logic [3:0]  tag;
        logic        mode;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst_n;

    logic        a_in_valid, a_in_ready, a_in_mode, a_out_valid, a_out_ready, a_out_mode;
    logic [7:0]  a_in_x, a_in_y;
    logic [3:0]  a_in_tag, a_out_tag;
    logic [15:0] a_out_z;
    logic [31:0] a_approx_cnt;

    logic        b_in_valid, b_in_ready, b_in_mode, b_out_valid, b_out_ready, b_out_mode;
    logic [11:0] b_in_x, b_in_y;
    logic [3:0]  b_in_tag, b_out_tag;
    logic [23:0] b_out_z;
    logic [31:0] b_approx_cnt;

    pam_approx_mult_pipe u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_x(a_in_x), .in_y(a_in_y),
        .in_mode(a_in_mode), .in_tag(a_in_tag),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_z(a_out_z),
        .out_tag(a_out_tag), .out_mode(a_out_mode), .approx_cnt(a_approx_cnt)
    );

    pam_approx_mult_pipe #(.WIDTH(12), .L(5), .KEEP_COL(10), .STAGES(2), .TAG_W(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_x(b_in_x), .in_y(b_in_y),
        .in_mode(b_in_mode), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_z(b_out_z),
        .out_tag(b_out_tag), .out_mode(b_out_mode), .approx_cnt(b_approx_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;
    int cyc = 0;
    bit lat_chk = 0;
    exp_t qa[$];
    exp_t qb[$];
    logic [63:0] a_exp, b_exp;
    int a_cnt_m = 0, b_cnt_m = 0, a_nout = 0;
    bit a_acc, b_acc, a_rdy_seen;
    bit a_stall_prev = 0, b_stall_prev = 0;
    logic [63:0] a_prev_z, b_prev_z;
    logic [3:0]  a_prev_tag, b_prev_tag;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [63:0] x, input logic [63:0] y, input logic mode,
                                          input int w, input int l, input int k);
        logic [63:0] r;
        logic b0, b1;
        if (!mode) return x * y;
        r = (y * (x >> l)) << l;
        for (int c = k; c <= 2 * w - 2; c++) begin
            for (int j = 0; j < l; j += 2) begin
                b0 = (c - j >= 0 && c - j < w) ? (x[j] & y[c-j]) : 1'b0;
                b1 = (j + 1 < l && c - j - 1 >= 0 && c - j - 1 < w) ? (x[j+1] & y[c-j-1]) : 1'b0;
                r  = r + (64'(b0 | b1) << c);
            end
        end
        return r & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    // One clock: sample both DUTs at the falling edge, then advance past the rising edge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (a_stall_prev) begin
            chk("a_hold_valid", 64'(a_out_valid), 64'd1);
            chk("a_hold_z", 64'(a_out_z), a_prev_z);
            chk("a_hold_tag", 64'(a_out_tag), 64'(a_prev_tag));
        end
        if (a_out_valid && a_out_ready) begin
            a_nout++;
            if (qa.size() == 0) chk("a_unexpected_out", 64'd1, 64'd0);
            else begin
                e = qa.pop_front();
                chk("a_z", 64'(a_out_z), e.z);
                chk("a_tag", 64'(a_out_tag), 64'(e.tag));
                chk("a_mode", 64'(a_out_mode), 64'(e.mode));
                if (lat_chk) chk("a_latency", 64'(cyc - e.cyc), 64'd2);
                if (e.mode) a_cnt_m++;
            end
        end
        if (b_stall_prev) begin
            chk("b_hold_z", 64'(b_out_z), b_prev_z);
            chk("b_hold_tag", 64'(b_out_tag), 64'(b_prev_tag));
        end
        if (b_out_valid && b_out_ready) begin
            if (qb.size() == 0) chk("b_unexpected_out", 64'd1, 64'd0);
            else begin
                e = qb.pop_front();
                chk("b_z", 64'(b_out_z), e.z);
                chk("b_tag", 64'(b_out_tag), 64'(e.tag));
                chk("b_mode", 64'(b_out_mode), 64'(e.mode));
                if (e.mode) b_cnt_m++;
            end
        end
        a_stall_prev = a_out_valid && !a_out_ready;
        a_prev_z = 64'(a_out_z);
        a_prev_tag = a_out_tag;
        b_stall_prev = b_out_valid && !b_out_ready;
        b_prev_z = 64'(b_out_z);
        b_prev_tag = b_out_tag;
        a_rdy_seen = a_in_ready;
        a_acc = a_in_valid && a_in_ready;
        b_acc = b_in_valid && b_in_ready;
        if (a_acc) begin
            e.z = a_exp; e.tag = a_in_tag; e.mode = a_in_mode; e.cyc = cyc;
            qa.push_back(e);
        end
        if (b_acc) begin
            e.z = b_exp; e.tag = b_in_tag; e.mode = b_in_mode; e.cyc = cyc;
            qb.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_out_ready = 1'b1;
        repeat (8) step();
    endtask

    logic [7:0]  d_x   [7] = '{8'd255, 8'd255, 8'd15, 8'd15, 8'd16, 8'd0, 8'd0};
    logic [7:0]  d_y   [7] = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd3, 8'd200, 8'd200};
    logic        d_m   [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [63:0] d_exp [7] = '{64'd63248, 64'd65025, 64'd2048, 64'd3825, 64'd48, 64'd0, 64'd0};

    initial begin
        int i, t;
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_x = '0; a_in_y = '0; a_in_mode = 1'b0; a_in_tag = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_x = '0; b_in_y = '0; b_in_mode = 1'b0; b_in_tag = '0; b_out_ready = 1'b1;
        a_exp = '0; b_exp = '0;

        #2;
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_out_z", 64'(a_out_z), 64'd0);
        chk("rst_out_tag", 64'(a_out_tag), 64'd0);
        chk("rst_out_mode", 64'(a_out_mode), 64'd0);
        chk("rst_approx_cnt", 64'(a_approx_cnt), 64'd0);
        @(posedge clk); @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 64'(a_in_ready), 64'd1);

        // Directed operands back to back; every result must arrive exactly two cycles later.
        lat_chk = 1;
        for (int k = 0; k < 7; k++) begin
            a_in_valid = 1'b1; a_in_x = d_x[k]; a_in_y = d_y[k];
            a_in_mode = d_m[k]; a_in_tag = 4'(k + 3); a_exp = d_exp[k];
            step();
            chk("dir_accept", 64'(a_acc), 64'd1);
        end
        drain();
        lat_chk = 0;
        chk("dir_all_out", 64'(qa.size()), 64'd0);
        chk("dir_approx_cnt", 64'(a_approx_cnt), 64'd4);

        // Eight ops with the consumer stalled in cycles 3..5.
        i = 0; t = 0;
        while (i < 8 && t < 40) begin
            a_in_valid = 1'b1;
            a_in_x = 8'(i * 37 + 5); a_in_y = 8'(255 - i * 29);
            a_in_mode = i[0]; a_in_tag = 4'(i);
            a_exp = model(64'(a_in_x), 64'(a_in_y), a_in_mode, 8, 4, 8);
            a_out_ready = !(t >= 3 && t <= 5);
            step();
            chk("bp_in_ready", 64'(a_rdy_seen), (t >= 3 && t <= 5) ? 64'd0 : 64'd1);
            if (a_acc) i++;
            t++;
        end
        chk("bp_all_sent", 64'(i), 64'd8);
        drain();
        chk("bp_all_out", 64'(qa.size()), 64'd0);
        chk("bp_approx_cnt", 64'(a_approx_cnt), 64'(a_cnt_m));

        // Reset with two ops in flight: both must vanish.
        a_out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            a_in_valid = 1'b1; a_in_x = 8'd200; a_in_y = 8'd99; a_in_mode = 1'b1; a_in_tag = 4'(k);
            a_exp = model(64'd200, 64'd99, 1'b1, 8, 4, 8);
            step();
        end
        rst_n = 1'b0;
        a_in_valid = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("mid_rst_approx_cnt", 64'(a_approx_cnt), 64'd0);
        qa.delete(); qb.delete();
        a_cnt_m = 0; b_cnt_m = 0;
        a_stall_prev = 0; b_stall_prev = 0;
        @(posedge clk); @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        a_nout = 0;
        repeat (5) step();
        chk("post_rst_no_out", 64'(a_nout), 64'd0);
        chk("post_rst_in_ready", 64'(a_rdy_seen), 64'd1);

        // Random traffic on both instances with random backpressure.
        a_in_valid = 1'b0; b_in_valid = 1'b0;
        a_acc = 0; b_acc = 0;
        for (int n = 0; n < 7000; n++) begin
            if (!a_in_valid || a_acc) begin
                a_in_valid = ($urandom_range(0, 3) != 0);
                a_in_x = 8'($urandom); a_in_y = 8'($urandom);
                a_in_mode = 1'($urandom); a_in_tag = 4'($urandom);
                a_exp = model(64'(a_in_x), 64'(a_in_y), a_in_mode, 8, 4, 8);
            end
            if (!b_in_valid || b_acc) begin
                b_in_valid = ($urandom_range(0, 3) != 0);
                b_in_x = 12'($urandom); b_in_y = 12'($urandom);
                b_in_mode = 1'($urandom); b_in_tag = 4'($urandom);
                b_exp = model(64'(b_in_x), 64'(b_in_y), b_in_mode, 12, 5, 10);
            end
            a_out_ready = ($urandom_range(0, 3) != 0);
            b_out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();
        chk("rnd_a_drained", 64'(qa.size()), 64'd0);
        chk("rnd_b_drained", 64'(qb.size()), 64'd0);
        chk("rnd_a_approx_cnt", 64'(a_approx_cnt), 64'(a_cnt_m));
        chk("rnd_b_approx_cnt", 64'(b_approx_cnt), 64'(b_cnt_m));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
